// File: rtl/cla_seq_add_ctrl.sv
// Sequential WIDTH-bit add/subtract controller that time-multiplexes one external
// 4-bit CLA slice, least significant nibble first, one nibble per clock.
module cla_seq_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [3:0]       sl_a,
  output logic [3:0]       sl_b,
  output logic             sl_ci,
  input  logic [3:0]       sl_s,
  input  logic             sl_co
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
      $error("cla_seq_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;

  // Signed overflow: operands agree in sign but the result sign differs.
  function automatic logic f_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign w_last   = (r_cnt == CW'(NIB - 1));
  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_a_sh   = r_a >> {r_cnt, 2'b00};
  assign w_b_sh   = r_b >> {r_cnt, 2'b00};

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    sl_a        = 4'd0;
    sl_b        = 4'd0;
    sl_ci       = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        sl_a  = w_a_sh[3:0];
        sl_b  = w_b_sh[3:0];
        sl_ci = r_carry;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Slice results are only looked at in RUN so undriven slice outputs stay out of state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a     <= op_a;
        r_b     <= sub ? ~op_b : op_b;
        r_carry <= sub | cin;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_sum[{r_cnt, 2'b00} +: 4] <= sl_s;
        r_carry                    <= sl_co;
        if (w_last) begin
          r_cnt  <= '0;
          r_cout <= sl_co;
          r_ovf  <= f_ovf(r_a[WIDTH-1], r_b[WIDTH-1], sl_s[3]);
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// Scoreboard bench for cla_seq_add_ctrl driving a behavioural 4-bit CLA slice.
module tb_cla_seq_add_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [3:0]   sl_a;
  logic [3:0]   sl_b;
  logic         sl_ci;
  logic [3:0]   sl_s;
  logic         sl_co;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_e;

  always #5 clk = ~clk;

  cla_seq_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf),
    .sl_a(sl_a), .sl_b(sl_b), .sl_ci(sl_ci), .sl_s(sl_s), .sl_co(sl_co)
  );

  // Behavioural carry-lookahead slice
  always_comb begin : slice
    logic [4:0] cc;
    cc[0] = sl_ci;
    for (int i = 0; i < 4; i++)
      cc[i+1] = (sl_a[i] & sl_b[i]) | ((sl_a[i] ^ sl_b[i]) & cc[i]);
    sl_s  = sl_a ^ sl_b ^ cc[3:0];
    sl_co = cc[4];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected result per delivered output
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: got sum=%h cout=%b ovf=%b, required no output", sum, cout, ovf);
        end else begin
          mon_e = exp_q.pop_front();
          check("result{sum,cout,ovf}", {14'd0, sum, cout, ovf}, {14'd0, mon_e});
        end
      end
    end
  end

  // Caller sits at a negedge; returns at the negedge after acceptance edge + NIB.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic s,
                       input logic [15:0] es, input logic eco, input logic eov, input bit chk_slice);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("wait_in_ready", {31'd0, in_ready}, 32'd1);
    op_a = a; op_b = b; cin = ci; sub = s; in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back({es, eco, eov});
    #1 in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("run_out_valid_low", {31'd0, out_valid}, 32'd0);
      check("run_in_ready_low", {31'd0, in_ready}, 32'd0);
      if (chk_slice)
        check("slice{a,b,ci}", {23'd0, sl_a, sl_b, sl_ci}, {23'd0, 4'(4 - k), 4'(k + 1), 1'b0});
    end
    @(negedge clk);
    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_sum_cout_ovf", {14'd0, sum, cout, ovf}, 32'd0);
    check("reset_slice_quiet", {23'd0, sl_a, sl_b, sl_ci}, 32'd0);

    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
    do_op(16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

    // Backpressure: hold result for three cycles with in_valid pulses
    @(negedge clk);
    out_ready = 1'b0;
    do_op(16'h00FF, 16'h0F0F, 1'b1, 1'b0, 16'h100F, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_result_stable", {14'd0, sum, cout, ovf}, {14'd0, 16'h100F, 1'b0, 1'b0});
      check("bp_slice_quiet", {23'd0, sl_a, sl_b, sl_ci}, 32'd0);
      op_a = 16'hAAAA; op_b = 16'h5555; in_valid = (i != 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    do_op(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0);

    // Reset during RUN at nibble 2: result must never appear
    @(negedge clk);
    @(negedge clk);
    op_a = 16'h1111; op_b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_sum_cout_ovf", {14'd0, sum, cout, ovf}, 32'd0);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      check("abort_no_stale_result", {31'd0, seen}, 32'd0);
    end
    do_op(16'h0001, 16'h0002, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
